seq_pattern_tx: RTL

Serial pattern transmitter that drives a bit stream carrying a fixed PAT_W-bit pattern (default 0111), repeated a programmable number of times, with a programmable idle gap between frames. It is the stimulus/source end of the serial sequence detectors: its `x` output connects directly to a detector's `x` input on the same clock. Control is a start/abort pulse interface. Status is reported through busy/done/frame-count outputs.

---
 rtl/seq_pattern_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter with repeat count, inter-frame gap and abort
module seq_pattern_tx #(
    parameter int               PAT_W    = 4,
    parameter logic [PAT_W-1:0] PATTERN  = 4'b0111,
    parameter logic             IDLE_BIT = 1'b1,
    parameter int               CNT_W    = 8,
    parameter int               GAP_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent
);

    localparam int             IW      = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IW-1:0]  IDX_TOP = IW'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state, state_n;
    logic [IW-1:0]      idx, idx_n;
    logic [GAP_W-1:0]   gcnt, gcnt_n;
    logic [GAP_W-1:0]   gap_q, gap_q_n;
    logic [CNT_W-1:0]   reps_q, reps_q_n;
    logic [CNT_W-1:0]   sent_n, sent_inc;

    assign sent_inc = sent + CNT_W'(1);

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        gcnt_n   = gcnt;
        gap_q_n  = gap_q;
        reps_q_n = reps_q;
        sent_n   = sent;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    sent_n = '0;
                    if (reps != '0) begin
                        reps_q_n = reps;
                        gap_q_n  = gap;
                        idx_n    = IDX_TOP;
                        state_n  = S_SEND;
                    end else begin
                        state_n  = S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_n = S_DONE;
                end else if (idx == '0) begin
                    sent_n = sent_inc;
                    if (sent_inc == reps_q) begin
                        state_n = S_DONE;
                    end else if (gap_q == '0) begin
                        idx_n = IDX_TOP;
                    end else begin
                        gcnt_n  = gap_q;
                        state_n = S_GAP;
                    end
                end else begin
                    idx_n = idx - IW'(1);
                end
            end
            S_GAP: begin
                // counter enters at gap, so leaving on 1 gives exactly gap idle cycles
                if (abort) begin
                    state_n = S_DONE;
                end else if (gcnt == GAP_W'(1)) begin
                    gcnt_n  = '0;
                    idx_n   = IDX_TOP;
                    state_n = S_SEND;
                end else begin
                    gcnt_n = gcnt - GAP_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // outputs are registered from the next-state values so they line up with the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            idx     <= IDX_TOP;
            gcnt    <= '0;
            gap_q   <= '0;
            reps_q  <= '0;
            sent    <= '0;
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            gcnt    <= gcnt_n;
            gap_q   <= gap_q_n;
            reps_q  <= reps_q_n;
            sent    <= sent_n;
            x       <= (state_n == S_SEND) ? PATTERN[idx_n] : IDLE_BIT;
            x_valid <= (state_n == S_SEND);
            busy    <= (state_n == S_SEND) || (state_n == S_GAP);
            done    <= (state_n == S_DONE);
        end
    end

endmodule
